uart_tx_arbiter: RTL and testbench

- Shares one UART byte transmitter between N_REQ requesters (e.g. loopback of the received byte, status reporter, debug dump).
- Round-robin arbitration with bounded bursts.
- Sequences the transmitter through a start/busy handshake.
- Sits between the requester logic and the TX serializer, and is the transmit-side counterpart of the receive path.

---
 rtl/uart_tx_arbiter_if.sv | 24 ++
 rtl/uart_tx_arbiter.sv | 136 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter handshake bundle for uart_tx_arbiter.
// master = arbiter side; slave = requesters plus TX serializer side.
interface uart_tx_arbiter_if #(
   parameter int N_REQ = 4
);
   logic [N_REQ-1:0]   i_req_valid;
   logic [8*N_REQ-1:0] i_req_data;
   logic [N_REQ-1:0]   o_req_ready;
   logic [N_REQ-1:0]   o_grant;
   logic               o_tx_start;
   logic [7:0]         o_tx_data;
   logic               i_tx_busy;
   logic               o_active;

   modport master (
      input  i_req_valid, i_req_data, i_tx_busy,
      output o_req_ready, o_grant, o_tx_start, o_tx_data, o_active
   );

   modport slave (
      output i_req_valid, i_req_data, i_tx_busy,
      input  o_req_ready, o_grant, o_tx_start, o_tx_data, o_active
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter between N_REQ requesters.
// Optional source-tag byte ahead of each grant: define UART_TX_ARB_SRC_TAG_EN.
module uart_tx_arbiter #(
   parameter int         N_REQ     = 4,
   parameter int         MAX_BURST = 4,
   parameter logic [3:0] TAG_HI    = 4'hA
) (
   input  logic              i_clk,
   input  logic              i_rst,
   uart_tx_arbiter_if.master bus
);
   // state   | meaning
   // S_IDLE  | no owner; pick next requester once the transmitter is free
   // S_TAG   | (tag build) load source tag byte for the new owner
   // S_LOAD  | ready pulse to owner; take its byte or drop the grant
   // S_START | tx_start pulse
   // S_GAP   | serializer raises busy; busy not yet trusted
   // S_WAIT  | frame in flight; then continue burst, send data after tag, or release

   localparam int               PW        = $clog2(N_REQ);
   localparam logic [N_REQ-1:0] ONE       = N_REQ'(1);
   localparam logic [7:0]       BURST_MAX = 8'(MAX_BURST);

`ifdef UART_TX_ARB_SRC_TAG_EN
   typedef enum logic [2:0] {S_IDLE, S_TAG, S_LOAD, S_START, S_GAP, S_WAIT} state_t;
   logic tag_pend;
`else
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_GAP, S_WAIT} state_t;
   logic unused_tag_hi;
   assign unused_tag_hi = ^TAG_HI;
`endif

   state_t        state;
   logic [PW-1:0] ptr;
   logic [PW-1:0] own;
   logic [PW-1:0] win_idx;
   logic          win_found;
   logic [PW:0]   cand;
   logic [7:0]    burst_cnt;

   // first valid requester after the pointer, wrapping modulo N_REQ
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int i = 1; i <= N_REQ; i++) begin
         cand = {1'b0, ptr} + (PW+1)'(i);
         if (cand >= (PW+1)'(N_REQ)) cand = cand - (PW+1)'(N_REQ);
         if (!win_found && bus.i_req_valid[cand[PW-1:0]]) begin
            win_found = 1'b1;
            win_idx   = cand[PW-1:0];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state           <= S_IDLE;
         ptr             <= PW'(N_REQ-1);
         own             <= '0;
         burst_cnt       <= '0;
         bus.o_req_ready <= '0;
         bus.o_grant     <= '0;
         bus.o_tx_start  <= 1'b0;
         bus.o_tx_data   <= 8'h00;
         bus.o_active    <= 1'b0;
`ifdef UART_TX_ARB_SRC_TAG_EN
         tag_pend        <= 1'b0;
`endif
      end else begin
         bus.o_req_ready <= '0;
         bus.o_tx_start  <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (win_found && !bus.i_tx_busy) begin
                  own          <= win_idx;
                  bus.o_grant  <= ONE << win_idx;
                  bus.o_active <= 1'b1;
`ifdef UART_TX_ARB_SRC_TAG_EN
                  tag_pend     <= 1'b1;
                  state        <= S_TAG;
`else
                  bus.o_req_ready <= ONE << win_idx;
                  state           <= S_LOAD;
`endif
               end
            end
`ifdef UART_TX_ARB_SRC_TAG_EN
            S_TAG: begin
               bus.o_tx_data  <= {TAG_HI, 4'(own)};
               bus.o_tx_start <= 1'b1;
               state          <= S_START;
            end
`endif
            S_LOAD: begin
               if (bus.i_req_valid[own]) begin
                  bus.o_tx_data  <= bus.i_req_data[8*own +: 8];
                  bus.o_tx_start <= 1'b1;
                  burst_cnt      <= burst_cnt + 8'd1;
                  state          <= S_START;
               end else begin
                  // withdrawal keeps the pointer but restarts the burst count
                  burst_cnt    <= '0;
                  bus.o_grant  <= '0;
                  bus.o_active <= 1'b0;
                  state        <= S_IDLE;
               end
            end
            S_START: state <= S_GAP;
            S_GAP:   state <= S_WAIT;
            S_WAIT: begin
               if (!bus.i_tx_busy) begin
`ifdef UART_TX_ARB_SRC_TAG_EN
                  if (tag_pend) begin
                     tag_pend        <= 1'b0;
                     bus.o_req_ready <= bus.o_grant;
                     state           <= S_LOAD;
                  end else
`endif
                  if (bus.i_req_valid[own] && burst_cnt < BURST_MAX) begin
                     bus.o_req_ready <= bus.o_grant;
                     state           <= S_LOAD;
                  end else begin
                     ptr          <= own;
                     burst_cnt    <= '0;
                     bus.o_grant  <= '0;
                     bus.o_active <= 1'b0;
                     state        <= S_IDLE;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: queued requesters, a busy-modelling
// transmitter, and a queue-based round-robin reference model.
module tb_uart_tx_arbiter;
   localparam int         N  = 4;
   localparam int         MB = 4;
   localparam logic [3:0] TH = 4'hA;
`ifdef UART_TX_ARB_SRC_TAG_EN
   localparam int TAGOFF = 1;
`else
   localparam int TAGOFF = 0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   uart_tx_arbiter_if #(.N_REQ(N)) bus ();

   uart_tx_arbiter #(.N_REQ(N), .MAX_BURST(MB), .TAG_HI(TH)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [7:0]   rq [N][$];
   logic [N-1:0] wd_mask   = '0;
   int           pend_pop  = -1;
   int           busy_left = 0;
   int           busy_len  = 4;

   logic [7:0] obs[$];
   int         obs_cyc[$];
   int         rdy_idx[$];
   int         rdy_cyc[$];
   logic [7:0] exp_b[$];
   int         exp_own[$];

   initial begin
      bus.i_req_valid = '0;
      bus.i_req_data  = '0;
      bus.i_tx_busy   = 1'b0;
   end

   // One clock: apply last transfer, sample, run transmitter, drive requesters.
   task automatic step();
      logic [N-1:0] rdy;
      logic [N-1:0] gnt;
      logic         cur_busy;
      @(posedge clk);
      #1;
      cyc++;
      if (pend_pop >= 0) begin
         void'(rq[pend_pop].pop_front());
         pend_pop = -1;
      end
      rdy      = bus.o_req_ready;
      gnt      = bus.o_grant;
      cur_busy = bus.i_tx_busy;
      if (!rst) begin
         checks++;
         if ($countones(gnt) > 1 || (rdy & ~gnt) != '0 || bus.o_active !== (gnt != '0) ||
             (cur_busy && (rdy != '0 || bus.o_tx_start))) begin
            errors++;
            $display("FAIL invariant cyc=%0d grant=%b ready=%b active=%b start=%b busy=%b (need onehot grant, ready in grant, active==|grant, quiet while busy)",
                     cyc, gnt, rdy, bus.o_active, bus.o_tx_start, cur_busy);
         end
      end
      if (bus.o_tx_start === 1'b1) begin
         obs.push_back(bus.o_tx_data);
         obs_cyc.push_back(cyc);
      end
      for (int k = 0; k < N; k++) begin
         if (rdy[k] === 1'b1) begin
            rdy_idx.push_back(k);
            rdy_cyc.push_back(cyc);
            if (rq[k].size() > 0 && !rst) pend_pop = k;
         end
      end
      if (busy_left > 0) begin
         bus.i_tx_busy = 1'b1;
         busy_left--;
      end else begin
         bus.i_tx_busy = 1'b0;
      end
      if (bus.o_tx_start === 1'b1) busy_left = (busy_len > 0) ? busy_len : int'($urandom_range(1, 12));
      for (int k = 0; k < N; k++) begin
         bus.i_req_valid[k]        = (rq[k].size() > 0) || wd_mask[k];
         bus.i_req_data[8*k +: 8]  = (rq[k].size() > 0) ? rq[k][0] : 8'h00;
      end
   endtask

   function automatic bit queues_empty();
      for (int k = 0; k < N; k++) if (rq[k].size() > 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic run_until_idle(input int budget, input string name);
      int n;
      n = 0;
      while (n < budget && !(queues_empty() && bus.o_active === 1'b0 &&
                             busy_left == 0 && bus.i_tx_busy === 1'b0)) begin
         step();
         n++;
      end
      checks++;
      if (n >= budget) begin
         errors++;
         $display("FAIL %s_timeout got %0d cycles without idle, required < %0d", name, n, budget);
      end
   endtask

   task automatic clear_logs();
      obs.delete(); obs_cyc.delete(); rdy_idx.delete(); rdy_cyc.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      clear_logs();
   endtask

   // Reference: serve nonempty queues in rotation from index 0, up to MB bytes per grant.
   task automatic build_model();
      int left[N];
      int pos[N];
      int ptr;
      int k;
      int n;
      exp_b.delete();
      exp_own.delete();
      ptr = N - 1;
      for (int i = 0; i < N; i++) begin
         left[i] = rq[i].size();
         pos[i]  = 0;
      end
      for (int g = 0; g < 1000; g++) begin
         k = -1;
         for (int d = 1; d <= N; d++)
            if (k < 0 && left[(ptr + d) % N] > 0) k = (ptr + d) % N;
         if (k < 0) break;
`ifdef UART_TX_ARB_SRC_TAG_EN
         exp_b.push_back({TH, 4'(k)});
`endif
         n = (left[k] < MB) ? left[k] : MB;
         for (int b = 0; b < n; b++) begin
            exp_b.push_back(rq[k][pos[k]]);
            exp_own.push_back(k);
            pos[k]++;
         end
         left[k] -= n;
         ptr = k;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      checks++;
      if (bus.o_req_ready !== '0 || bus.o_grant !== '0 || bus.o_tx_start !== 1'b0 ||
          bus.o_tx_data !== 8'h00 || bus.o_active !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs got ready=%b grant=%b start=%b data=%h active=%b, required all 0",
                  bus.o_req_ready, bus.o_grant, bus.o_tx_start, bus.o_tx_data, bus.o_active);
      end
      rst = 1'b0;
      clear_logs();
   endtask

   task automatic test_latency();
      int t;
      do_reset();
      busy_len = 3;
      rq[2].push_back(8'h5A);
      step();
      t = cyc;
      run_until_idle(100, "latency");
      checks++;
      if (rdy_idx.size() != 1 || rdy_idx[0] != 2) begin
         errors++;
         $display("FAIL latency_ready_owner got %0d pulses first=%0d, required 1 pulse on 2", rdy_idx.size(), rdy_idx[0]);
      end
      checks++;
      if (rdy_cyc[0] != t + 1 + TAGOFF * 6) begin
         errors++;
         $display("FAIL latency_ready_cycle got %0d, required %0d", rdy_cyc[0] - t, 1 + TAGOFF * 6);
      end
      checks++;
      if (obs.size() != 1 + TAGOFF || obs[TAGOFF] !== 8'h5A || obs_cyc[TAGOFF] != rdy_cyc[0] + 1) begin
         errors++;
         $display("FAIL latency_start got %0d starts data=%h at +%0d, required %0d starts data=5a at ready+1",
                  obs.size(), obs[TAGOFF], obs_cyc[TAGOFF] - rdy_cyc[0], 1 + TAGOFF);
      end
`ifdef UART_TX_ARB_SRC_TAG_EN
      checks++;
      if (obs[0] !== {TH, 4'h2}) begin
         errors++;
         $display("FAIL latency_tag got %h, required %h", obs[0], {TH, 4'h2});
      end
`endif
   endtask

   task automatic test_round_robin();
      do_reset();
      busy_len = 0;
      for (int k = 0; k < N; k++)
         for (int b = 0; b < 6; b++) rq[k].push_back(8'($urandom));
      build_model();
      step();
      run_until_idle(3000, "round_robin");
      checks++;
      if (obs.size() != exp_b.size() || rdy_idx.size() != 24) begin
         errors++;
         $display("FAIL rr_count got %0d starts %0d readies, required %0d starts 24 readies",
                  obs.size(), rdy_idx.size(), exp_b.size());
      end
      for (int i = 0; i < obs.size() && i < exp_b.size(); i++) begin
         checks++;
         if (obs[i] !== exp_b[i]) begin
            errors++;
            $display("FAIL rr_byte[%0d] got %h, required %h", i, obs[i], exp_b[i]);
         end
      end
      // four full bursts in order, then the two-byte remainders in order
      for (int i = 0; i < rdy_idx.size() && i < 24; i++) begin
         checks++;
         if (rdy_idx[i] != ((i < 16) ? i / 4 : (i - 16) / 2)) begin
            errors++;
            $display("FAIL rr_owner[%0d] got %0d, required %0d", i, rdy_idx[i], (i < 16) ? i / 4 : (i - 16) / 2);
         end
      end
   endtask

   task automatic test_burst_mix();
      int exp_o[7];
      exp_o = '{1, 1, 1, 1, 3, 1, 1};
      do_reset();
      busy_len = 10;
      for (int b = 1; b <= 6; b++) rq[1].push_back(8'(b));
      rq[3].push_back(8'($urandom));
      build_model();
      step();
      run_until_idle(1000, "burst_mix");
      checks++;
      if (rdy_idx.size() != 7 || obs.size() != exp_b.size()) begin
         errors++;
         $display("FAIL burst_count got %0d readies %0d starts, required 7 readies %0d starts",
                  rdy_idx.size(), obs.size(), exp_b.size());
      end
      for (int i = 0; i < rdy_idx.size() && i < 7; i++) begin
         checks++;
         if (rdy_idx[i] != exp_o[i]) begin
            errors++;
            $display("FAIL burst_owner[%0d] got %0d, required %0d", i, rdy_idx[i], exp_o[i]);
         end
      end
      for (int i = 0; i < obs.size() && i < exp_b.size(); i++) begin
         checks++;
         if (obs[i] !== exp_b[i]) begin
            errors++;
            $display("FAIL burst_byte[%0d] got %h, required %h", i, obs[i], exp_b[i]);
         end
      end
   endtask

   task automatic test_busy_hold();
      do_reset();
      busy_len = 50;
      rq[0].push_back(8'h11);
      rq[0].push_back(8'h22);
      step();
      run_until_idle(400, "busy_hold");
      checks++;
      if (rdy_cyc.size() != 2 || obs.size() != 2 + TAGOFF) begin
         errors++;
         $display("FAIL busy_counts got %0d readies %0d starts, required 2 and %0d", rdy_cyc.size(), obs.size(), 2 + TAGOFF);
      end
      checks++;
      if (rdy_cyc[1] != obs_cyc[TAGOFF] + 52) begin
         errors++;
         $display("FAIL busy_next_ready got start+%0d, required start+52", rdy_cyc[1] - obs_cyc[TAGOFF]);
      end
      checks++;
      if (obs[1 + TAGOFF] !== 8'h22 || obs_cyc[1 + TAGOFF] != rdy_cyc[1] + 1) begin
         errors++;
         $display("FAIL busy_second_start got %h at ready+%0d, required 22 at ready+1",
                  obs[1 + TAGOFF], obs_cyc[1 + TAGOFF] - rdy_cyc[1]);
      end
   endtask

   task automatic test_withdraw();
      do_reset();
      busy_len = 3;
      wd_mask  = 4'b0010;
      step();
      wd_mask  = '0;
      step();
      step();
      run_until_idle(100, "withdraw");
      checks++;
      if (rdy_idx.size() != 1 || rdy_idx[0] != 1 || obs.size() != TAGOFF) begin
         errors++;
         $display("FAIL withdraw got %0d readies (first %0d) %0d starts, required 1 ready on 1 and %0d starts",
                  rdy_idx.size(), rdy_idx[0], obs.size(), TAGOFF);
      end
      clear_logs();
      rq[1].push_back(8'h44);
      rq[2].push_back(8'h55);
      step();
      run_until_idle(200, "withdraw_ptr");
      checks++;
      if (rdy_idx.size() != 2 || rdy_idx[0] != 1) begin
         errors++;
         $display("FAIL withdraw_pointer got first owner %0d, required 1", rdy_idx[0]);
      end
   endtask

   task automatic test_reset_wait();
      int n;
      do_reset();
      busy_len = 20;
      rq[3].push_back(8'hC3);
      rq[3].push_back(8'hD3);
      n = 0;
      step();
      while (obs.size() == 0 && n < 30) begin
         step();
         n++;
      end
      checks++;
      if (obs.size() == 0) begin
         errors++;
         $display("FAIL rst_wait_start got no start within 30 cycles, required one");
      end
      step();
      step();
      step();
      rst = 1'b1;
      step();
      checks++;
      if (bus.o_req_ready !== '0 || bus.o_grant !== '0 || bus.o_tx_start !== 1'b0 ||
          bus.o_tx_data !== 8'h00 || bus.o_active !== 1'b0) begin
         errors++;
         $display("FAIL rst_wait_outputs got ready=%b grant=%b start=%b data=%h active=%b, required all 0",
                  bus.o_req_ready, bus.o_grant, bus.o_tx_start, bus.o_tx_data, bus.o_active);
      end
      rst = 1'b0;
      clear_logs();
      rq[0].push_back(8'h30);
      step();
      run_until_idle(600, "rst_wait");
      checks++;
      if (rdy_idx.size() < 2 || rdy_idx[0] != 0 || rdy_idx[1] != 3) begin
         errors++;
         $display("FAIL rst_wait_order got %0d readies first=%0d second=%0d, required 0 then 3",
                  rdy_idx.size(), rdy_idx[0], rdy_idx[1]);
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 4; it++) begin
         do_reset();
         busy_len = 0;
         for (int k = 0; k < N; k++) begin
            int cnt;
            cnt = int'($urandom_range(0, 7));
            for (int b = 0; b < cnt; b++) rq[k].push_back(8'($urandom));
         end
         build_model();
         step();
         run_until_idle(3000, "random");
         checks++;
         if (obs.size() != exp_b.size() || rdy_idx.size() != exp_own.size()) begin
            errors++;
            $display("FAIL rand%0d_count got %0d starts %0d readies, required %0d and %0d",
                     it, obs.size(), rdy_idx.size(), exp_b.size(), exp_own.size());
         end
         for (int i = 0; i < obs.size() && i < exp_b.size(); i++) begin
            checks++;
            if (obs[i] !== exp_b[i]) begin
               errors++;
               $display("FAIL rand%0d_byte[%0d] got %h, required %h", it, i, obs[i], exp_b[i]);
            end
         end
         for (int i = 0; i < rdy_idx.size() && i < exp_own.size(); i++) begin
            checks++;
            if (rdy_idx[i] != exp_own[i]) begin
               errors++;
               $display("FAIL rand%0d_owner[%0d] got %0d, required %0d", it, i, rdy_idx[i], exp_own[i]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_round_robin();
      test_burst_mix();
      test_busy_hold();
      test_withdraw();
      test_reset_wait();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got no finish by cycle %0d, required earlier finish", cyc);
      $fatal(1, "watchdog");
   end
endmodule
